// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe: operand beat in, result beat out.
interface addsub_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             sat_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, op, sat_en, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, op, sat_en, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero
    );
endinterface

// File: rtl/addsub_pipe.sv
// Two-stage handshaked add/sub/accumulate pipeline with optional signed saturation.
// Stage 1 captures operands; stage 2 holds the computed result, flags and accumulator.
module addsub_pipe #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset_l,
    addsub_pipe_if.slave  bus
);
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [1:0]       s1_op;
    logic             s1_sat;

    logic             s2_valid;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             overflow_q;
    logic             zero_q;
    logic [WIDTH-1:0] acc;

    logic             s2_free;
    logic             advance;
    logic             accept;

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] result_d;
    logic             carry_d;
    logic             overflow_d;

    assign s2_free      = !s2_valid || bus.out_ready;
    assign advance      = s1_valid && s2_free;
    assign bus.in_ready = reset_l && (!s1_valid || s2_free);
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid = s2_valid;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;

    // Accumulate reads the live accumulator, which is current because it updates on the same transfer edge.
    always_comb begin
        x          = s1_a;
        y          = s1_b;
        full       = '0;
        result_d   = s1_a;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        if (s1_op != 2'b11) begin
            if (s1_op == 2'b10) begin
                x = acc;
                y = s1_a;
            end
            if (s1_op == 2'b01) begin
                full       = {1'b0, x} - {1'b0, y};
                overflow_d = (x[WIDTH-1] != y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
            end else begin
                full       = {1'b0, x} + {1'b0, y};
                overflow_d = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
            end
            carry_d = full[WIDTH];
            if (s1_sat && overflow_d) begin
                result_d = x[WIDTH-1] ? SAT_MIN : SAT_MAX;
            end else begin
                result_d = full[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= 2'b00;
            s1_sat   <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= bus.a;
            s1_b     <= bus.b;
            s1_op    <= bus.op;
            s1_sat   <= bus.sat_en;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            s2_valid   <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            acc        <= '0;
        end else if (advance) begin
            s2_valid   <= 1'b1;
            result_q   <= result_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            zero_q     <= (result_d == '0);
            if (s1_op[1]) begin
                acc <= result_d;
            end
        end else if (bus.out_ready) begin
            s2_valid <= 1'b0;
        end
    end
endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
Parametrised, handshaked two-stage arithmetic pipeline. It is the successor to the team's fixed 8-bit registered adder and subtractor. Adds a selectable op (add, sub, accumulate, load), optional signed saturation, status flags and valid/ready flow control. It sits between operand sources and result consumers on the datapath and sustains one op per cycle.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  in  1  clock; all state updates on rising edge
reset_l  in  1  reset, asynchronous, active-low
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept operand beat
a  in  WIDTH  operand A
b  in  WIDTH  operand B (ignored for ops 10/11)
op  in  2  00 add, 01 sub, 10 acc += a, 11 acc = a
sat_en  in  1  1 = clamp signed overflow to max/min
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
carry  out  1  add: carry-out; sub: borrow (a < b unsigned); acc add: carry-out; load: 0
overflow  out  1  signed overflow of the unclamped op (reported even when saturated)
zero  out  1  result == 0 (after saturation)

Behaviour:
- Reset (reset_l low, async): s1_valid=0, s2_valid=0, out_valid=0, result=0, carry=0, overflow=0, zero=0, accumulator=0. in_ready=0 while reset_l low. Any in-flight beats are discarded.
- Stage 1 registers a, b, op, sat_en.
- Stage 2 computes and registers result and flags.
- Handshake:
  - s2_free = !s2_valid || out_ready.
  - s1 advances into s2 when s1_valid && s2_free.
  - in_ready = reset_l && (!s1_valid || s2_free).
  - Input accepted when in_valid && in_ready. Output consumed when out_valid && out_ready.
  - in_ready is combinational from out_ready; no combinational path from in_valid to in_ready.
- Latency: an accepted beat appears on out_valid exactly 2 cycles after acceptance when out_ready is held high. Throughput is 1 beat/cycle.
- Backpressure:
  - While out_ready is low with out_valid high, result and flags hold stable.
  - The pipeline fills to 2 beats, then in_ready drops.
  - No beat is lost, duplicated or reordered.
- Arithmetic is computed on the s1->s2 transfer, at WIDTH+1 bits:
  - add: full = a + b; carry = full[WIDTH].
  - sub: full = a - b; carry = borrow.
  - overflow (add) = sign(a)==sign(b) && sign(sum)!=sign(a).
  - overflow (sub) = sign(a)!=sign(b) && sign(diff)!=sign(a).
  - op 10: acc + a with add rules; the accumulator takes the (possibly saturated) result.
  - op 11: result = a, accumulator = a, carry=0, overflow=0.
  - The accumulator updates only on an s1->s2 transfer of op 10/11. Ops 00/01 never touch it.
- Back-to-back accumulate: the accumulator read by an op-10 transfer is the value after all earlier transfers. This holds because the accumulator register updates on the same edge. No bubbles are permitted.
- Saturation (sat_en=1, signed overflow):
  - Positive overflow -> result = 2^(WIDTH-1)-1.
  - Negative overflow -> result = -2^(WIDTH-1).
  - carry is unaffected.
  - With sat_en=0, result wraps modulo 2^WIDTH.
- Simultaneous consume and accept in the same cycle is allowed with both stages full. Steady-state streaming must not stall.
- Reset asserted mid-stream: all state clears on the asserting edge. Output after release reflects only post-reset inputs.

Test Plan:
- WIDTH=8, op=00, a=0x7F, b=0x01:
  - sat_en=0 -> result 0x80, overflow 1, carry 0, zero 0.
  - sat_en=1 -> result 0x7F, overflow 1.
  - out_valid exactly 2 cycles after accept.
- op=01:
  - a=0x05, b=0x07 -> 0xFE, carry(borrow) 1, overflow 0.
  - a=0x80, b=0x01, sat_en=1 -> 0x80, overflow 1.
  - a=0x05, b=0x05 -> 0x00, zero 1.
- Accumulate stream, in_valid high on consecutive cycles, out_ready=1: op=11 a=0x10, then op=10 a=0x05 three times -> results 0x10, 0x15, 0x1A, 0x1F on 4 consecutive cycles.
- Backpressure:
  - Stream 6 add beats (a=i, b=1) with out_ready low for cycles 3-6 -> in_ready low once both stages are full.
  - Results 1..6 delivered in order, none lost or duplicated.
  - result held stable while stalled.
- Reset mid-stream:
  - Drop reset_l with both stages full -> out_valid=0, result=0, in_ready=0 immediately.
  - After release: op=10 a=0x03 -> 0x03 (accumulator cleared).
- Accumulator saturation, sat_en=1: load 0x70, then acc += 0x20 -> 0x7F, overflow 1. Next acc += 0x01 -> 0x7F, overflow 1.
